// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W = 4;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, restore on borrow.
module div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] r_cur,
    input  logic         q_msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0]   a;
    logic [W-1:0] b_n;
    logic [W-1:0] diff;
    logic [W+1:0] c;

    assign a    = {r_cur, q_msb};
    assign b_n  = ~d;
    assign c[0] = 1'b1;

    // Ripple chain computing a + ~{0,d} + 1; a carry out of the top means no borrow.
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign diff[i]  = a[i] ^ b_n[i] ^ c[i];
        assign c[i + 1] = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end

    // Top bit subtracts the zero-extension, so its inverted operand is constant 1.
    assign c[W + 1] = a[W] | c[W];

    assign q_bit  = c[W + 1];
    assign r_next = q_bit ? diff : a[W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider with start/busy/done handshake,
// one quotient bit per clock. Optional macro DIV_ZERO_EARLY_EN adds a dbz
// output and a one-edge completion path for a zero divisor.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured when start is seen
//  RUN   | iterating, one quotient bit per edge, count counts down from W
//  DONE  | done pulse; quotient/remainder just updated
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
`ifdef DIV_ZERO_EARLY_EN
    output logic         dbz,
`endif
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    div_state_t    state, state_next;
    logic [CW-1:0] count;
    logic [W-1:0]  q_reg, r_reg, d_reg;
    logic [W-1:0]  r_step;
    logic          q_step;
    logic          load, step_en, finish;
`ifdef DIV_ZERO_EARLY_EN
    logic          early_dbz;
`endif

    div_step #(.W(W)) u_step (
        .r_cur  (r_reg),
        .q_msb  (q_reg[W-1]),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
`ifdef DIV_ZERO_EARLY_EN
        early_dbz  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_EARLY_EN
                    if (divisor == '0) begin
                        early_dbz  = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
`else
                    load       = 1'b1;
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                step_en = 1'b1;
                // Terminal count: this edge takes count to zero.
                if (count == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_EARLY_EN
            dbz       <= 1'b0;
`endif
        end else begin
            if (load) begin
                q_reg <= dividend;
                d_reg <= divisor;
                r_reg <= '0;
                count <= CW'(W);
            end
            if (step_en) begin
                q_reg <= {q_reg[W-2:0], q_step};
                r_reg <= r_step;
                count <= count - CW'(1);
            end
            if (finish) begin
                quotient  <= {q_reg[W-2:0], q_step};
                remainder <= r_step;
`ifdef DIV_ZERO_EARLY_EN
                dbz       <= 1'b0;
`endif
            end
`ifdef DIV_ZERO_EARLY_EN
            if (early_dbz) begin
                quotient  <= '1;
                remainder <= dividend;
                dbz       <= 1'b1;
            end
`endif
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed table, handshake
// corner sequences, random operands against an arithmetic model, exhaustive sweep.
module tb_seq_restoring_divider;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
`ifdef DIV_ZERO_EARLY_EN
    logic         dbz;
`endif

    int checks = 0;
    int passes = 0;

    seq_restoring_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef DIV_ZERO_EARLY_EN
        .dbz       (dbz),
`endif
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = MAXV;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input int b);
`ifdef DIV_ZERO_EARLY_EN
        return (b == 0) ? 0 : W;
`else
        return W;
`endif
    endfunction

    function automatic int exp_dbz(input int b);
        return (b == 0) ? 1 : 0;
    endfunction

    function automatic int get_dbz();
`ifdef DIV_ZERO_EARLY_EN
        return int'(dbz);
`else
        return 0;
`endif
    endfunction

    // Launch a divide from IDLE; lat = edges after the accepting edge until done.
    task automatic run_div(input int a, input int b, output int q, output int r,
                           output int lat, output int busy_cyc, output int dz,
                           output int tail);
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        q  = int'(quotient);
        r  = int'(remainder);
        dz = get_dbz();
        tail = int'(busy);
        @(posedge clk); #1;
        tail = tail + 2 * int'(done);
    endtask

    vec_t tbl[8];
    int q, r, lat, bc, dz, tail, eq, er, cyc;

    initial begin
        tbl[0] = '{15, 4, 3, 3};
        tbl[1] = '{9, 3, 3, 0};
        tbl[2] = '{5, 9, 0, 5};
        tbl[3] = '{0, 7, 0, 0};
        tbl[4] = '{15, 1, 15, 0};
        tbl[5] = '{10, 0, 15, 10};
        tbl[6] = '{7, 7, 1, 0};
        tbl[7] = '{1, 15, 0, 1};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quotient), 0);
        check("rst_rem", int'(remainder), 0);
        check("rst_dbz", get_dbz(), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_div(tbl[i].a, tbl[i].b, q, r, lat, bc, dz, tail);
            check($sformatf("tbl%0d_quot", i), q, tbl[i].q);
            check($sformatf("tbl%0d_rem", i), r, tbl[i].r);
            check($sformatf("tbl%0d_lat", i), lat, exp_lat(tbl[i].b));
            check($sformatf("tbl%0d_busy_cycles", i), bc, exp_lat(tbl[i].b));
            check($sformatf("tbl%0d_busy_at_done_or_long_pulse", i), tail, 0);
`ifdef DIV_ZERO_EARLY_EN
            check($sformatf("tbl%0d_dbz", i), dz, exp_dbz(tbl[i].b));
`endif
        end

        // Start pulses during RUN and DONE must not disturb 12/5.
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("ign_busy_run", int'(busy), 1);
        dividend = 4'd3;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ign_lat", cyc, W);
        check("ign_quot_done", int'(quotient), 2);
        check("ign_rem_done", int'(remainder), 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_quot", int'(quotient), 2);
        check("ign_rem", int'(remainder), 2);
        check("ign_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("ign_no_relaunch", int'(busy) + int'(done), 0);

        // Asynchronous reset mid-divide discards everything.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_quot", int'(quotient), 0);
        check("arst_rem", int'(remainder), 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_discard", int'(busy) + int'(done), 0);
        run_div(14, 3, q, r, lat, bc, dz, tail);
        check("arst_fresh_quot", q, 4);
        check("arst_fresh_rem", r, 2);
        check("arst_fresh_lat", lat, W);

        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(MAXV, 0));
            b = int'($urandom_range(MAXV, 0));
            if (i % 8 == 0) b = 0;
            model(a, b, eq, er);
            run_div(a, b, q, r, lat, bc, dz, tail);
            check($sformatf("rnd_%0d/%0d_quot", a, b), q, eq);
            check($sformatf("rnd_%0d/%0d_rem", a, b), r, er);
            check($sformatf("rnd_%0d/%0d_lat", a, b), lat, exp_lat(b));
`ifdef DIV_ZERO_EARLY_EN
            check($sformatf("rnd_%0d/%0d_dbz", a, b), dz, exp_dbz(b));
`endif
        end

        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 1; b <= MAXV; b++) begin
                run_div(a, b, q, r, lat, bc, dz, tail);
                check($sformatf("exh_%0d/%0d_identity", a, b), q * b + r, a);
                check($sformatf("exh_%0d/%0d_rem_lt_div", a, b), int'(r < b), 1);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
